// File: rtl/cntr_down_timer.sv
// Loadable synchronous down-counter/timer with a one-cycle terminal-count pulse.
// Optional periodic mode: define CNTR_DOWN_AUTO_RELOAD_EN to reload the start value at terminal count.
//
// Load handshake: a load is taken on any rising edge where load_valid && load_ready.
// load_ready depends only on state (high in IDLE). load_value is sampled only on that edge.
module cntr_down_timer #(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   stop,
  input  logic                   load_valid,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic                   load_ready,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   tc,
  output logic                   dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

`ifdef CNTR_DOWN_AUTO_RELOAD_EN
  logic [COUNT_WIDTH-1:0] reload_reg;
`endif

  assign load_ready = (state == IDLE);
  assign dbg_state  = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      tc    <= 1'b0;
`ifdef CNTR_DOWN_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            count <= load_value;
`ifdef CNTR_DOWN_AUTO_RELOAD_EN
            reload_reg <= load_value;
`endif
            if (load_value != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              // Zero-length timer: expire immediately without entering RUN.
              tc <= 1'b1;
            end
          end
        end
        RUN: begin
          // stop outranks a simultaneous terminal decrement: count stays put, no tc.
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (en) begin
            if (count > COUNT_WIDTH'(1)) begin
              count <= count - COUNT_WIDTH'(1);
            end else if (count == COUNT_WIDTH'(1)) begin
              tc <= 1'b1;
`ifdef CNTR_DOWN_AUTO_RELOAD_EN
              count <= reload_reg;
`else
              count <= '0;
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cntr_down_timer.sv
// Directed self-checking bench for cntr_down_timer; honours CNTR_DOWN_AUTO_RELOAD_EN when defined.
module tb_cntr_down_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         stop;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] exp_q[$];

  cntr_down_timer #(.COUNT_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .stop       (stop),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver: advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] c, input logic t, input logic b);
    check_eq({tag, "_count"}, 32'(count), 32'(c));
    check_eq({tag, "_tc"},    32'(tc),    32'(t));
    check_eq({tag, "_busy"},  32'(busy),  32'(b));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  // Scoreboard: drain exp_q one edge per entry; tc expected only where flagged.
  task automatic run_expect(input string tag, input logic [W-1:0] last_tc_count, input bit tc_on_last);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      check_eq({tag, "_count"}, 32'(count), 32'(e));
      check_eq({tag, "_tc"}, 32'(tc),
               32'(tc_on_last && exp_q.size() == 0 && e == last_tc_count));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; stop = 1'b0; load_valid = 1'b1; load_value = 4'd7;

    // 1. Reset with a load offered: nothing taken.
    step(); step();
    check_outs("reset", 4'd0, 1'b0, 1'b0);
    check_eq("reset_ready", 32'(load_ready), 32'd1);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    load_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_outs("post_reset", 4'd0, 1'b0, 1'b0);

`ifndef CNTR_DOWN_AUTO_RELOAD_EN
    // 2. Load 5, en held high.
    en = 1'b1;
    do_load(4'd5);
    check_outs("load5", 4'd5, 1'b0, 1'b1);
    check_eq("load5_ready", 32'(load_ready), 32'd0);
    exp_q = '{4'd4, 4'd3, 4'd2, 4'd1};
    run_expect("cnt5", 4'd0, 1'b0);
    step();
    check_outs("cnt5_tc", 4'd0, 1'b1, 1'b0);
    check_eq("cnt5_ready", 32'(load_ready), 32'd1);
    step();
    check_outs("cnt5_after", 4'd0, 1'b0, 1'b0);

    // 3. Load 3, en toggled, a load of 9 offered during RUN.
    do_load(4'd3);
    check_outs("load3", 4'd3, 1'b0, 1'b1);
    load_valid = 1'b1; load_value = 4'd9;
    en = 1'b1; step(); check_outs("tog1", 4'd2, 1'b0, 1'b1);
    en = 1'b0; step(); check_outs("tog0a", 4'd2, 1'b0, 1'b1);
    load_valid = 1'b0;
    en = 1'b1; step(); check_outs("tog1b", 4'd1, 1'b0, 1'b1);
    en = 1'b0; step(); check_outs("tog0b", 4'd1, 1'b0, 1'b1);
    en = 1'b1; step(); check_outs("tog_tc", 4'd0, 1'b1, 1'b0);

    // 4a. Zero-length timer.
    en = 1'b0;
    do_load(4'd0);
    check_outs("load0", 4'd0, 1'b1, 1'b0);
    step();
    check_outs("load0_after", 4'd0, 1'b0, 1'b0);

    // 4b. Stop together with the terminal decrement.
    en = 1'b1;
    do_load(4'd4);
    exp_q = '{4'd3, 4'd2, 4'd1};
    run_expect("cnt4", 4'd0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("stop_tc", 4'd1, 1'b0, 1'b0);
    check_eq("stop_state", 32'(dbg_state), 32'd0);
    en = 1'b0;
    step();
    check_outs("stop_hold", 4'd1, 1'b0, 1'b0);

    // 5. Reset mid-count.
    en = 1'b1;
    do_load(4'd3);
    step();
    check_outs("pre_rst", 4'd2, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    check_outs("mid_rst", 4'd0, 1'b0, 1'b0);
    check_eq("mid_rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    step();
    check_outs("mid_rst_after", 4'd0, 1'b0, 1'b0);

    // Boundary: load of the maximum value 15 expires after 15 edges.
    do_load(4'd15);
    for (int i = 14; i >= 1; i--) exp_q.push_back(W'(i));
    run_expect("cnt15", 4'd0, 1'b0);
    step();
    check_outs("cnt15_tc", 4'd0, 1'b1, 1'b0);
`else
    // Periodic mode: load 3, en=1 -> 3,2,1,3,2,1,... with tc when reloaded.
    en = 1'b1;
    do_load(4'd3);
    check_outs("ar_load", 4'd3, 1'b0, 1'b1);
    step(); check_outs("ar_2a", 4'd2, 1'b0, 1'b1);
    step(); check_outs("ar_1a", 4'd1, 1'b0, 1'b1);
    step(); check_outs("ar_3a", 4'd3, 1'b1, 1'b1);
    check_eq("ar_ready", 32'(load_ready), 32'd0);
    step(); check_outs("ar_2b", 4'd2, 1'b0, 1'b1);
    step(); check_outs("ar_1b", 4'd1, 1'b0, 1'b1);
    step(); check_outs("ar_3b", 4'd3, 1'b1, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("ar_stop", 4'd3, 1'b0, 1'b0);

    // Reload value 1: tc on every enabled cycle.
    do_load(4'd1);
    step(); check_outs("ar1_a", 4'd1, 1'b1, 1'b1);
    step(); check_outs("ar1_b", 4'd1, 1'b1, 1'b1);
    en = 1'b0;
    step(); check_outs("ar1_hold", 4'd1, 1'b0, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_outs("ar1_stop", 4'd1, 1'b0, 1'b0);

    // Reset mid-count clears everything.
    en = 1'b1;
    do_load(4'd3);
    step();
    rst_n = 1'b0;
    step();
    check_outs("ar_rst", 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
